// File: rtl/mem_stage_hs_if.sv
// mem_stage_hs_if: data-memory request/ack bus.
// master = memory stage, slave = data memory.
interface mem_stage_hs_if #(
    parameter int D_WIDTH = 32
);
    logic                 mem_req;
    logic                 mem_we;
    logic [D_WIDTH/8-1:0] mem_be;
    logic [D_WIDTH-1:0]   mem_addr;
    logic [D_WIDTH-1:0]   mem_wdata;
    logic                 mem_ack;
    logic [D_WIDTH-1:0]   mem_rdata;

    modport master (
        output mem_req, mem_we, mem_be, mem_addr, mem_wdata,
        input  mem_ack, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_be, mem_addr, mem_wdata,
        output mem_ack, mem_rdata
    );
endinterface

// File: rtl/mem_stage_hs.sv
// mem_stage_hs: RISC-V memory stage, variable-latency req/ack + MEM/WB reg.
// Optional MEM_MISALIGN_TRAP_EN: misaligned h/w/d accesses abort with BusErrW.
module mem_stage_hs #(
    parameter int D_WIDTH = 32,
    parameter int A_WIDTH = 5,
    parameter int TIMEOUT = 15
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               RegWriteM,
    input  logic               MemReadM,
    input  logic               MemWriteM,
    input  logic [1:0]         ResultSrcM,
    input  logic [2:0]         Funct3M,
    input  logic [A_WIDTH-1:0] RdM,
    input  logic [D_WIDTH-1:0] ALUResultM,
    input  logic [D_WIDTH-1:0] WriteDataM,
    input  logic [D_WIDTH-1:0] PCPlus4M,
    mem_stage_hs_if.master     bus,
    output logic               StallM,
    output logic               RegWriteW,
    output logic [1:0]         ResultSrcW,
    output logic [A_WIDTH-1:0] RdW,
    output logic [D_WIDTH-1:0] ALUResultW,
    output logic [D_WIDTH-1:0] ReadDataW,
    output logic [D_WIDTH-1:0] PCPlus4W,
    output logic               BusErrW
);
    localparam int NB = D_WIDTH / 8;
    localparam int OB = $clog2(NB);
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    typedef enum logic {
        S_IDLE,
        S_WAIT
    } state_e;

    state_e             state_q;
    logic [7:0]         cnt_q;

    logic               rw_q;
    logic               berr_q;
    logic [1:0]         rsrc_q;
    logic [A_WIDTH-1:0] rd_q;
    logic [D_WIDTH-1:0] alu_q;
    logic [D_WIDTH-1:0] rdata_q;
    logic [D_WIDTH-1:0] pc4_q;

    logic [1:0]         size;
    logic [OB-1:0]      off;
    logic [NB-1:0]      mask;
    logic [D_WIDTH-1:0] wdata;
    logic [D_WIDTH-1:0] rshift;
    logic [D_WIDTH-1:0] rfmt;
    logic               is_mem;
    logic               misalign;
    logic               access;
    logic               timeout;
    logic               bus_err;
    logic               req;

    assign is_mem = MemReadM | MemWriteM;
    assign off    = ALUResultM[OB-1:0];

    // Effective access size; doubleword folds to word on a 32-bit datapath.
    always_comb begin
        size = Funct3M[1:0];
        if (D_WIDTH == 32 && size == 2'b11) begin
            size = 2'b10;
        end
    end

    // Byte-enable mask for the access size, before lane shift.
    always_comb begin
        unique case (size)
            2'b00:   mask = NB'(1);
            2'b01:   mask = NB'(3);
            2'b10:   mask = NB'(15);
            default: mask = '1;
        endcase
    end

    // Replicate store data across every lane of its size.
    always_comb begin
        wdata = '0;
        for (int i = 0; i < NB; i++) begin
            unique case (size)
                2'b00:   wdata[8*i +: 8] = WriteDataM[7:0];
                2'b01:   wdata[8*i +: 8] = WriteDataM[8*(i%2) +: 8];
                2'b10:   wdata[8*i +: 8] = WriteDataM[8*(i%4) +: 8];
                default: wdata[8*i +: 8] = WriteDataM[8*i +: 8];
            endcase
        end
    end

    assign rshift = bus.mem_rdata >> {off, 3'b000};

    // Sign- or zero-extend the selected load lane.
    always_comb begin
        unique case (size)
            2'b00: rfmt = Funct3M[2] ? D_WIDTH'(rshift[7:0])
                                     : D_WIDTH'($signed(rshift[7:0]));
            2'b01: rfmt = Funct3M[2] ? D_WIDTH'(rshift[15:0])
                                     : D_WIDTH'($signed(rshift[15:0]));
            2'b10: rfmt = Funct3M[2] ? D_WIDTH'(rshift[31:0])
                                     : D_WIDTH'($signed(rshift[31:0]));
            default: rfmt = rshift;
        endcase
    end

`ifdef MEM_MISALIGN_TRAP_EN
    // Natural-alignment check on the low address bits.
    always_comb begin
        unique case (size)
            2'b00:   misalign = 1'b0;
            2'b01:   misalign = is_mem & off[0];
            2'b10:   misalign = is_mem & (|off[1:0]);
            default: misalign = is_mem & (|off);
        endcase
    end
`else
    assign misalign = 1'b0;
`endif

    assign access  = is_mem & ~misalign;
    assign timeout = (state_q == S_WAIT) && (cnt_q == TO_LAST);
    assign req     = ~rst & ((state_q == S_WAIT) | access);
    assign StallM  = req & ~bus.mem_ack & ~timeout;
    assign bus_err = misalign | (timeout & ~bus.mem_ack);

    assign bus.mem_req   = req;
    assign bus.mem_we    = MemWriteM;
    assign bus.mem_be    = mask << off;
    assign bus.mem_addr  = {ALUResultM[D_WIDTH-1:OB], {OB{1'b0}}};
    assign bus.mem_wdata = wdata;

    // Handshake FSM with wait counter for the ack timeout.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (access && !bus.mem_ack) begin
                        state_q <= S_WAIT;
                        cnt_q   <= '0;
                    end
                end
                S_WAIT: begin
                    if (bus.mem_ack || timeout) begin
                        state_q <= S_IDLE;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // MEM/WB register; a stall inserts a bubble and holds the data fields.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rw_q    <= 1'b0;
            berr_q  <= 1'b0;
            rsrc_q  <= '0;
            rd_q    <= '0;
            alu_q   <= '0;
            rdata_q <= '0;
            pc4_q   <= '0;
        end else if (StallM) begin
            rw_q   <= 1'b0;
            berr_q <= 1'b0;
        end else begin
            rw_q    <= RegWriteM & ~bus_err;
            berr_q  <= bus_err;
            rsrc_q  <= ResultSrcM;
            rd_q    <= RdM;
            alu_q   <= ALUResultM;
            rdata_q <= rfmt;
            pc4_q   <= PCPlus4M;
        end
    end

    assign RegWriteW  = rw_q;
    assign BusErrW    = berr_q;
    assign ResultSrcW = rsrc_q;
    assign RdW        = rd_q;
    assign ALUResultW = alu_q;
    assign ReadDataW  = rdata_q;
    assign PCPlus4W   = pc4_q;
endmodule

// File: tb/tb_mem_stage_hs.sv
// tb_mem_stage_hs: directed vectors, W results checked by a scoreboard monitor.
// Memory model acks after a per-vector delay.
module tb_mem_stage_hs;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        RegWriteM = 1'b0;
    logic        MemReadM = 1'b0;
    logic        MemWriteM = 1'b0;
    logic [1:0]  ResultSrcM = '0;
    logic [2:0]  Funct3M = '0;
    logic [4:0]  RdM = '0;
    logic [31:0] ALUResultM = '0;
    logic [31:0] WriteDataM = '0;
    logic [31:0] PCPlus4M = '0;
    logic        StallM;
    logic        RegWriteW;
    logic [1:0]  ResultSrcW;
    logic [4:0]  RdW;
    logic [31:0] ALUResultW;
    logic [31:0] ReadDataW;
    logic [31:0] PCPlus4W;
    logic        BusErrW;

    mem_stage_hs_if #(.D_WIDTH(32)) bus ();

    mem_stage_hs dut (
        .clk        (clk),
        .rst        (rst),
        .RegWriteM  (RegWriteM),
        .MemReadM   (MemReadM),
        .MemWriteM  (MemWriteM),
        .ResultSrcM (ResultSrcM),
        .Funct3M    (Funct3M),
        .RdM        (RdM),
        .ALUResultM (ALUResultM),
        .WriteDataM (WriteDataM),
        .PCPlus4M   (PCPlus4M),
        .bus        (bus),
        .StallM     (StallM),
        .RegWriteW  (RegWriteW),
        .ResultSrcW (ResultSrcW),
        .RdW        (RdW),
        .ALUResultW (ALUResultW),
        .ReadDataW  (ReadDataW),
        .PCPlus4W   (PCPlus4W),
        .BusErrW    (BusErrW)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          tag;
        logic        rw;
        logic        be;
        logic [1:0]  rs;
        logic [4:0]  rd;
        logic [31:0] alu;
        logic [31:0] rdv;
        logic        ck;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   total = 0;
    int   bad = 0;

    task automatic chk(input string nm, input int tag,
                       input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s[%0d]: got %h want %h", nm, tag, act, exp);
        end
    endtask

    task automatic push(input int tag, input logic rw, input logic be,
                        input logic [1:0] rs, input logic [4:0] rd,
                        input logic [31:0] alu, input logic [31:0] rdv,
                        input logic ck);
        exp_t e;
        e.tag = tag; e.rw = rw; e.be = be; e.rs = rs;
        e.rd = rd; e.alu = alu; e.rdv = rdv; e.ck = ck;
        sb.push_back(e);
    endtask

    // Monitor: every W write (RegWriteW or BusErrW) consumes one expectation.
    always @(negedge clk) begin
        if (!rst && (RegWriteW || BusErrW)) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL wb_unexpected: got rd=%0d alu=%h want none",
                         RdW, ALUResultW);
            end else begin
                mon_e = sb.pop_front();
                chk("wb_regwrite", mon_e.tag, 32'(RegWriteW), 32'(mon_e.rw));
                chk("wb_buserr", mon_e.tag, 32'(BusErrW), 32'(mon_e.be));
                chk("wb_rsrc", mon_e.tag, 32'(ResultSrcW), 32'(mon_e.rs));
                chk("wb_rd", mon_e.tag, 32'(RdW), 32'(mon_e.rd));
                chk("wb_alu", mon_e.tag, ALUResultW, mon_e.alu);
                chk("wb_pc4", mon_e.tag, PCPlus4W, mon_e.alu + 32'd4);
                if (mon_e.ck) chk("wb_rdata", mon_e.tag, ReadDataW, mon_e.rdv);
            end
        end
    end

    task automatic access(
        input int tag, input logic rdm, input logic wrm, input logic rwm,
        input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wd,
        input logic [31:0] rdat, input logic [4:0] rd, input int ack_dly,
        input int exp_stall, input logic exp_req, input logic chk_bus,
        input logic [3:0] exp_be, input logic [31:0] exp_addr,
        input logic [31:0] exp_wdata);
        int stalls;
        int k;
        bit done;
        @(negedge clk);
        RegWriteM  = rwm;
        MemReadM   = rdm;
        MemWriteM  = wrm;
        ResultSrcM = rdm ? 2'b01 : 2'b00;
        Funct3M    = f3;
        RdM        = rd;
        ALUResultM = addr;
        WriteDataM = wd;
        PCPlus4M   = addr + 32'd4;
        stalls = 0;
        k = 0;
        done = 1'b0;
        while (!done && k < 40) begin
            bus.mem_ack   = (k == ack_dly);
            bus.mem_rdata = rdat;
            #1;
            if (k == 0) begin
                chk("req", tag, 32'(bus.mem_req), 32'(exp_req));
                if (chk_bus) begin
                    chk("addr", tag, bus.mem_addr, exp_addr);
                    chk("be", tag, 32'(bus.mem_be), 32'(exp_be));
                    chk("wdata", tag, bus.mem_wdata, exp_wdata);
                    chk("we", tag, 32'(bus.mem_we), 32'(wrm));
                end
            end else begin
                chk("bubble", tag, {30'd0, BusErrW, RegWriteW}, 32'd0);
            end
            if (!StallM) begin
                done = 1'b1;
            end else begin
                stalls++;
                @(negedge clk);
            end
            k++;
        end
        if (!done) begin
            total++;
            bad++;
            $display("FAIL hang[%0d]: got stall after %0d cycles want release",
                     tag, k);
        end
        chk("stall_cycles", tag, 32'(stalls), 32'(exp_stall));
    endtask

    task automatic nop(input logic ack);
        @(negedge clk);
        RegWriteM = 1'b0;
        MemReadM = 1'b0;
        MemWriteM = 1'b0;
        ResultSrcM = '0;
        bus.mem_ack = ack;
        #1;
        chk("nop_req", 0, 32'(bus.mem_req), 32'd0);
        chk("nop_stall", 0, 32'(StallM), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        bus.mem_ack = 1'b0;
        bus.mem_rdata = '0;
        #1;
        chk("rst_rw", 0, 32'(RegWriteW), 32'd0);
        chk("rst_berr", 0, 32'(BusErrW), 32'd0);
        chk("rst_alu", 0, ALUResultW, 32'd0);
        chk("rst_rdata", 0, ReadDataW, 32'd0);
        chk("rst_req", 0, 32'(bus.mem_req), 32'd0);
        chk("rst_stall", 0, 32'(StallM), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // lw zero-wait
        push(1, 1, 0, 2'b01, 5'd5, 32'h100, 32'hDEADBEEF, 1);
        access(1, 1, 0, 1, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 5'd5,
               0, 0, 1, 1, 4'hF, 32'h100, 32'h0);
        // lb / lbu, 3-cycle wait, back to back
        push(2, 1, 0, 2'b01, 5'd6, 32'h103, 32'hFFFFFF80, 1);
        access(2, 1, 0, 1, 3'b000, 32'h103, 32'h0, 32'h80FF0000, 5'd6,
               3, 3, 1, 0, 4'h0, 32'h0, 32'h0);
        push(3, 1, 0, 2'b01, 5'd6, 32'h103, 32'h00000080, 1);
        access(3, 1, 0, 1, 3'b100, 32'h103, 32'h0, 32'h80FF0000, 5'd6,
               3, 3, 1, 0, 4'h0, 32'h0, 32'h0);
        // stores: sh, sb, sw
        access(4, 0, 1, 0, 3'b001, 32'h202, 32'h1234, 32'h0, 5'd0,
               1, 1, 1, 1, 4'b1100, 32'h200, 32'h12341234);
        access(5, 0, 1, 0, 3'b000, 32'h201, 32'hAB, 32'h0, 5'd0,
               0, 0, 1, 1, 4'b0010, 32'h200, 32'hABABABAB);
        access(6, 0, 1, 0, 3'b010, 32'h204, 32'h11223344, 32'h0, 5'd0,
               0, 0, 1, 1, 4'hF, 32'h204, 32'h11223344);
        // lh / lhu
        push(7, 1, 0, 2'b01, 5'd8, 32'h102, 32'hFFFF8001, 1);
        access(7, 1, 0, 1, 3'b001, 32'h102, 32'h0, 32'h80011234, 5'd8,
               0, 0, 1, 0, 4'h0, 32'h0, 32'h0);
        push(8, 1, 0, 2'b01, 5'd8, 32'h100, 32'h00001234, 1);
        access(8, 1, 0, 1, 3'b101, 32'h100, 32'h0, 32'h80011234, 5'd8,
               0, 0, 1, 0, 4'h0, 32'h0, 32'h0);
        // non-memory op: no handshake
        push(9, 1, 0, 2'b00, 5'd9, 32'hCAFE, 32'h0, 0);
        access(9, 0, 0, 1, 3'b000, 32'hCAFE, 32'h0, 32'h0, 5'd9,
               99, 0, 0, 0, 4'h0, 32'h0, 32'h0);
        // stray ack with no request, then 2-wait load
        nop(1'b1);
        push(10, 1, 0, 2'b01, 5'd10, 32'h108, 32'h42, 1);
        access(10, 1, 0, 1, 3'b010, 32'h108, 32'h0, 32'h42, 5'd10,
               2, 2, 1, 0, 4'h0, 32'h0, 32'h0);
        // no ack: timeout after 15 stall cycles
        push(11, 0, 1, 2'b01, 5'd7, 32'h300, 32'h0, 0);
        access(11, 1, 0, 1, 3'b010, 32'h300, 32'h0, 32'h0, 5'd7,
               99, 15, 1, 0, 4'h0, 32'h0, 32'h0);
        // misaligned lw
`ifdef MEM_MISALIGN_TRAP_EN
        push(12, 0, 1, 2'b01, 5'd4, 32'h101, 32'h0, 0);
        access(12, 1, 0, 1, 3'b010, 32'h101, 32'h0, 32'hDEADBEEF, 5'd4,
               99, 0, 0, 0, 4'h0, 32'h0, 32'h0);
`else
        push(12, 1, 0, 2'b01, 5'd4, 32'h101, 32'h00DEADBE, 1);
        access(12, 1, 0, 1, 3'b010, 32'h101, 32'h55667788, 32'hDEADBEEF,
               5'd4, 0, 0, 1, 1, 4'b1110, 32'h100, 32'h55667788);
`endif
        // reset in the middle of a wait
        @(negedge clk);
        RegWriteM = 1'b1;
        MemReadM = 1'b1;
        ResultSrcM = 2'b01;
        Funct3M = 3'b010;
        RdM = 5'd3;
        ALUResultM = 32'h400;
        PCPlus4M = 32'h404;
        bus.mem_ack = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("wait_stall", 13, 32'(StallM), 32'd1);
        rst = 1'b1;
        #1;
        chk("mrst_rw", 13, 32'(RegWriteW), 32'd0);
        chk("mrst_berr", 13, 32'(BusErrW), 32'd0);
        chk("mrst_alu", 13, ALUResultW, 32'd0);
        chk("mrst_pc4", 13, PCPlus4W, 32'd0);
        chk("mrst_rd", 13, 32'(RdW), 32'd0);
        chk("mrst_stall", 13, 32'(StallM), 32'd0);
        chk("mrst_req", 13, 32'(bus.mem_req), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        RegWriteM = 1'b0;
        MemReadM = 1'b0;
        // back in IDLE: zero-wait load completes without stall
        push(14, 1, 0, 2'b01, 5'd11, 32'h10C, 32'h7F, 1);
        access(14, 1, 0, 1, 3'b010, 32'h10C, 32'h0, 32'h7F, 5'd11,
               0, 0, 1, 0, 4'h0, 32'h0, 32'h0);
        nop(1'b0);
        nop(1'b0);
        @(negedge clk);
        chk("sb_empty", 0, 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mem_stage_hs.md
# mem_stage_hs

Parametrised RISC-V memory stage with a variable-latency data-memory handshake, byte/halfword/word load-store formatting, stall generation and a built-in MEM/WB pipeline register. It sits between the execute-to-memory register and the writeback mux. It replaces the fixed single-cycle data-memory path with a request/ack protocol. When the memory is slow it freezes the upstream pipeline and inserts bubbles into writeback.

## Interface
- D_WIDTH, 32, datapath width (32 or 64)
- A_WIDTH, 5, register-index width
- TIMEOUT, 15, max wait cycles for `mem_ack` before a bus error (1..255)
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- RegWriteM, MemReadM, MemWriteM  in  1 each  M-stage controls
- ResultSrcM  in  2  writeback select
- Funct3M  in  3  access size/sign (000 lb, 001 lh, 010 lw, 011 ld, 100 lbu, 101 lhu, 110 lwu)
- RdM  in  A_WIDTH  destination register
- ALUResultM, WriteDataM, PCPlus4M  in  D_WIDTH each  address/result, store data, link value
- mem_req  out  1  access request
- mem_we  out  1  write enable
- mem_be  out  D_WIDTH/8  byte enables
- mem_addr  out  D_WIDTH  word-aligned address
- mem_wdata  out  D_WIDTH  lane-shifted store data
- mem_ack  in  1  access complete; `mem_rdata` valid for reads
- mem_rdata  in  D_WIDTH  raw read word
- StallM  out  1  hold all upstream stages this cycle
- RegWriteW  out  1
- ResultSrcW  out  2
- RdW  out  A_WIDTH
- ALUResultW, ReadDataW, PCPlus4W  out  D_WIDTH each
- BusErrW  out  1  access aborted by timeout or misalignment

## Operation
- FSM states:
  - IDLE → WAIT: on `MemReadM|MemWriteM` with no `mem_ack` in the same cycle.
  - WAIT → IDLE: on `mem_ack` or on timeout.
  - All other cases hold the current state.
- `mem_req` is high in IDLE when an access is present, and in every WAIT cycle. Address, data, `be` and `we` are combinational from the M inputs, which are stable because StallM holds upstream.
- `StallM = mem_req & ~mem_ack & ~timeout`.
- Wait counter: cleared on IDLE→WAIT, incremented each WAIT cycle. Timeout fires when count == TIMEOUT-1 in WAIT. On timeout, complete with RegWriteW=0 and BusErrW=1.
- Store lanes:
  - `mem_wdata` holds the store data replicated per size.
  - `mem_be` = size mask << `addr[log2(D_WIDTH/8)-1:0]`.
- Load format: select the byte lane of `mem_rdata` by the low address bits, then sign- or zero-extend per Funct3M. The result is registered into ReadDataW.
- Illegal Funct3M for the width (ld/lwu when D_WIDTH=32) is treated as a word access.
- MEM/WB register:
  - Loads when `~StallM`.
  - While StallM is high it loads a bubble (RegWriteW=0, BusErrW=0); the other W fields hold their previous values.
- Non-memory instructions pass in one cycle with no handshake.

## Timing
- Reset: state=IDLE, counter=0, and every W output = 0. `mem_req`/`StallM` then evaluate to 0 while no access is present.
- Zero-wait memory (`mem_ack` in the request cycle): 1-cycle latency, no stall.
- N-wait memory: StallM high for N cycles; W fields valid in the cycle after `mem_ack`.
- `mem_ack` while `mem_req`=0 is ignored.
- Reset during WAIT aborts the access immediately; no W update.
- Back-to-back accesses: a new request may be issued in the cycle immediately after `mem_ack`.

## Configuration
- `MEM_MISALIGN_TRAP_EN` defined:
  - Misaligned halfword, word or doubleword accesses suppress `mem_req`.
  - They complete in one cycle with BusErrW=1 and RegWriteW=0.
- Undefined: misaligned offsets are used as-is. Enables and lanes are computed from the low bits, and bytes beyond the word boundary are dropped.

## Test plan
- Zero-wait `lw` at 0x100, `mem_rdata`=0xDEADBEEF, ack same cycle → no stall; next cycle ReadDataW=0xDEADBEEF, RegWriteW=1.
- `lb` at 0x103, `mem_rdata`=0x80FF_0000, ack after 3 cycles → StallM high for 3 cycles, bubbles in W; then ReadDataW=0xFFFFFF80. Repeat with `lbu` → 0x00000080.
- `sh` at 0x202 with WriteDataM=0x1234 → `mem_be`=4'b1100, `mem_wdata`=0x12341234, `mem_addr`=0x200, `mem_we`=1.
- No ack, TIMEOUT=15 → StallM high for exactly 15 cycles, then BusErrW=1, RegWriteW=0, state back to IDLE.
- Assert `rst` mid-WAIT → all W outputs 0, StallM 0 in the same cycle, state IDLE.
- With `MEM_MISALIGN_TRAP_EN`, `lw` at 0x101 → `mem_req` never asserted; next cycle BusErrW=1, RegWriteW=0.
